// File: rtl/hdc_lfsr.sv
// rtl/hdc_lfsr.sv - free-running Fibonacci LFSR bit source; optional lock-up escape via LFSR_LOCKUP_GUARD_EN
module hdc_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = 16'b1001010010110101,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic clk,
    input  logic nrst,
    output logic out
);

    logic [WIDTH-1:0] state;
    logic             fb;

    always_comb begin
        fb = ^(state & TAPS);
`ifdef LFSR_LOCKUP_GUARD_EN
        // Injecting a 1 only when the register is all zeros leaves every nonzero trajectory untouched.
        fb = fb ^ (state == '0);
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= SEED;
        end else begin
            state <= {state[WIDTH-2:0], fb};
        end
    end

    assign out = state[WIDTH-1];

endmodule

// File: tb/tb_hdc_lfsr.sv
// tb/tb_hdc_lfsr.sv - randomized self-checking bench for hdc_lfsr against a bit-stream recurrence model
`timescale 1ns/1ps
module tb_hdc_lfsr;

`ifdef LFSR_LOCKUP_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam logic [15:0] DSEED = 16'h94B5;
    localparam logic [15:0] DTAPS = 16'hB400;

    logic clk = 1'b0;
    logic nrst_a, nrst_z, nrst_4;
    logic out_a, out_z, out_4;

    int vectors = 0;
    int errors  = 0;
    bit stream[];

    always #5 clk = ~clk;

    hdc_lfsr u_dut (.clk(clk), .nrst(nrst_a), .out(out_a));

    hdc_lfsr #(.WIDTH(16), .SEED(16'h0000), .TAPS(16'hB400)) u_zero (
        .clk(clk), .nrst(nrst_z), .out(out_z)
    );

    hdc_lfsr #(.WIDTH(4), .SEED(4'b0001), .TAPS(4'b1100)) u_w4 (
        .clk(clk), .nrst(nrst_4), .out(out_4)
    );

    // Output bit k is stream[k]; the first width bits are the seed MSB first, each later bit is
    // the parity of the tapped positions of the width-bit window that precedes it.
    task automatic gen_stream(input int width, input logic [15:0] seed, input logic [15:0] taps, input int n);
        stream = new[n + width];
        for (int k = 0; k < width; k++) stream[k] = seed[width-1-k];
        for (int k = width; k < n + width; k++) begin
            bit f;
            bit allz;
            f = 1'b0;
            allz = 1'b1;
            for (int i = 0; i < width; i++) begin
                bit si;
                si = stream[k - 1 - i];
                if (taps[i]) f = f ^ si;
                if (si) allz = 1'b0;
            end
            if (GUARD && allz) f = ~f;
            stream[k] = f;
        end
    endtask

    function automatic logic [15:0] exp_state(input int t, input int width);
        logic [15:0] s;
        s = '0;
        for (int j = 0; j < width; j++) s[j] = stream[t + width - 1 - j];
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset_a(input int off);
        @(posedge clk);
        #(off);
        nrst_a = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        assert_reset_a(2);
        vectors++;
        if (u_dut.state !== DSEED) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", u_dut.state, DSEED);
        end
        vectors++;
        if (out_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_out got %b expected 1", out_a);
        end
        repeat (2) step();
        vectors++;
        if (u_dut.state !== DSEED) begin
            errors++;
            $display("FAIL reset_hold got %h expected %h", u_dut.state, DSEED);
        end
    endtask

    task automatic test_sequence();
        logic [18:0]  golden;
        logic [15:0]  early [1:3];
        golden = 19'b1001010010110101111;
        early[1] = 16'h296B;
        early[2] = 16'h52D7;
        early[3] = 16'hA5AF;
        gen_stream(16, DSEED, DTAPS, 32);
        @(negedge clk);
        nrst_a = 1'b1;
        #1;
        vectors++;
        if (out_a !== golden[18]) begin
            errors++;
            $display("FAIL seq_bit0 got %b expected %b", out_a, golden[18]);
        end
        for (int t = 1; t <= 20; t++) begin
            step();
            vectors++;
            if (u_dut.state !== exp_state(t, 16)) begin
                errors++;
                $display("FAIL seq_state t=%0d got %h expected %h", t, u_dut.state, exp_state(t, 16));
            end
            vectors++;
            if (out_a !== stream[t]) begin
                errors++;
                $display("FAIL seq_out t=%0d got %b expected %b", t, out_a, stream[t]);
            end
            if (t < 19) begin
                vectors++;
                if (out_a !== golden[18-t]) begin
                    errors++;
                    $display("FAIL seq_golden t=%0d got %b expected %b", t, out_a, golden[18-t]);
                end
            end
            if (t <= 3) begin
                vectors++;
                if (u_dut.state !== early[t]) begin
                    errors++;
                    $display("FAIL seq_early t=%0d got %h expected %h", t, u_dut.state, early[t]);
                end
            end
        end
    endtask

    // Runs len edges from a fresh release of nrst_a, comparing with the model each edge.
    task automatic run_checked_a(input string tag, input int len);
        @(negedge clk);
        nrst_a = 1'b1;
        for (int t = 1; t <= len; t++) begin
            step();
            vectors++;
            if (u_dut.state !== exp_state(t, 16) || out_a !== stream[t]) begin
                errors++;
                $display("FAIL %s t=%0d got %h/%b expected %h/%b", tag, t, u_dut.state, out_a,
                         exp_state(t, 16), stream[t]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        n = 100 + int'($urandom_range(0, 50));
        gen_stream(16, DSEED, DTAPS, 64);
        repeat (n) step();
        assert_reset_a(int'($urandom_range(1, 7)));
        vectors++;
        if (u_dut.state !== DSEED || out_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got %h/%b expected %h/1", u_dut.state, out_a, DSEED);
        end
        run_checked_a("mid_restart", 40);
    endtask

    task automatic test_random_resets();
        for (int it = 0; it < 6; it++) begin
            int len;
            int hold;
            len = int'($urandom_range(1, 40));
            hold = int'($urandom_range(1, 3));
            assert_reset_a(int'($urandom_range(1, 8)));
            vectors++;
            if (u_dut.state !== DSEED) begin
                errors++;
                $display("FAIL rnd_reset it=%0d got %h expected %h", it, u_dut.state, DSEED);
            end
            repeat (hold) step();
            vectors++;
            if (u_dut.state !== DSEED) begin
                errors++;
                $display("FAIL rnd_hold it=%0d got %h expected %h", it, u_dut.state, DSEED);
            end
            run_checked_a("rnd_run", len);
        end
    endtask

    task automatic test_period();
        int  first_ret;
        bit  zero_seen;
        first_ret = 0;
        zero_seen = 1'b0;
        gen_stream(16, DSEED, DTAPS, 65535);
        assert_reset_a(3);
        @(negedge clk);
        nrst_a = 1'b1;
        for (int t = 1; t <= 65535; t++) begin
            step();
            vectors++;
            if (u_dut.state !== exp_state(t, 16)) begin
                errors++;
                if (errors < 20)
                    $display("FAIL period_state t=%0d got %h expected %h", t, u_dut.state, exp_state(t, 16));
            end
            if (u_dut.state == 16'h0000) zero_seen = 1'b1;
            if (u_dut.state == DSEED && first_ret == 0) first_ret = t;
        end
        vectors++;
        if (first_ret !== 65535) begin
            errors++;
            $display("FAIL period_return got %0d expected 65535", first_ret);
        end
        vectors++;
        if (zero_seen !== 1'b0) begin
            errors++;
            $display("FAIL period_zero got %b expected 0", zero_seen);
        end
    endtask

    task automatic test_seed_zero();
        int first_one;
        first_one = 0;
        gen_stream(16, 16'h0000, DTAPS, 100);
        @(posedge clk);
        #2;
        nrst_z = 1'b0;
        #1;
        vectors++;
        if (u_zero.state !== 16'h0000 || out_z !== 1'b0) begin
            errors++;
            $display("FAIL zero_reset got %h/%b expected 0000/0", u_zero.state, out_z);
        end
        @(negedge clk);
        nrst_z = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            step();
            vectors++;
            if (u_zero.state !== exp_state(t, 16)) begin
                errors++;
                $display("FAIL zero_state t=%0d got %h expected %h", t, u_zero.state, exp_state(t, 16));
            end
            if (out_z === 1'b1 && first_one == 0) first_one = t;
`ifdef LFSR_LOCKUP_GUARD_EN
            if (t == 1) begin
                vectors++;
                if (u_zero.state !== 16'h0001) begin
                    errors++;
                    $display("FAIL zero_escape got %h expected 0001", u_zero.state);
                end
            end
`else
            vectors++;
            if (out_z !== 1'b0) begin
                errors++;
                $display("FAIL zero_locked t=%0d got %b expected 0", t, out_z);
            end
`endif
        end
`ifdef LFSR_LOCKUP_GUARD_EN
        vectors++;
        if (first_one !== 16) begin
            errors++;
            $display("FAIL zero_first_one got %0d expected 16", first_one);
        end
`endif
    endtask

    task automatic test_width4();
        int seen [16];
        int first_ret;
        first_ret = 0;
        for (int s = 0; s < 16; s++) seen[s] = 0;
        gen_stream(4, 16'h0001, 16'h000C, 20);
        @(posedge clk);
        #2;
        nrst_4 = 1'b0;
        #1;
        vectors++;
        if (u_w4.state !== 4'b0001 || out_4 !== 1'b0) begin
            errors++;
            $display("FAIL w4_reset got %h/%b expected 1/0", u_w4.state, out_4);
        end
        @(negedge clk);
        nrst_4 = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            logic [15:0] e;
            step();
            e = exp_state(t, 4);
            vectors++;
            if (u_w4.state !== e[3:0] || out_4 !== stream[t]) begin
                errors++;
                $display("FAIL w4_state t=%0d got %h/%b expected %h/%b", t, u_w4.state, out_4, e[3:0], stream[t]);
            end
            seen[int'(u_w4.state)]++;
            if (u_w4.state == 4'b0001 && first_ret == 0) first_ret = t;
        end
        for (int s = 1; s < 16; s++) begin
            vectors++;
            if (seen[s] !== 1) begin
                errors++;
                $display("FAIL w4_visit state=%0d got %0d expected 1", s, seen[s]);
            end
        end
        vectors++;
        if (first_ret !== 15) begin
            errors++;
            $display("FAIL w4_period got %0d expected 15", first_ret);
        end
    endtask

    initial begin
        nrst_a = 1'b1;
        nrst_z = 1'b1;
        nrst_4 = 1'b1;
        test_reset();
        test_sequence();
        test_mid_reset();
        test_random_resets();
        test_period();
        test_seed_zero();
        test_width4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
